// File: rtl/clken_nco.sv
// rtl/clken_nco.sv - PLL lock qualifier, core reset sequencer and fractional clock-enable NCO
// Outputs are registered from the next state, so they change on the same edge the FSM does.
module clken_nco #(
  parameter int          ACC_W     = 24,
  parameter int unsigned INC       = 2797618,
  parameter int          LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  output logic ce,
  output logic ce_p1,
  output logic ce_p2,
  output logic core_rst_n,
  output logic locked
);

  localparam int CNT_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [ACC_W:0] INC_W = (ACC_W+1)'(INC);

  if (longint'(INC) >= (longint'(1) << ACC_W)) begin : g_inc_range
    $error("clken_nco: INC must be below 2**ACC_W");
  end
  if (LOCK_WAIT < 1) begin : g_wait_range
    $error("clken_nco: LOCK_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               phase_q, phase_d;
  logic               sync1_q, sync2_q;
  logic               lock_s;
  logic               ce_q, ce_p1_q, ce_p2_q, run_q;

  assign lock_s = sync2_q;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        settle_cnt_d = '0;
        if (lock_s) state_d = SETTLE;
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d      = WAIT_LOCK;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == CNT_W'(LOCK_WAIT - 1)) begin
          state_d      = RUN;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        settle_cnt_d = '0;
        if (!lock_s) state_d = WAIT_LOCK;
      end
      default: begin
        state_d      = WAIT_LOCK;
        settle_cnt_d = '0;
      end
    endcase
  end

  // The accumulator advances on every edge that lands in RUN, so the first RUN cycle already
  // holds one increment taken from zero and the carry out of that sum is the next ce.
  always_comb begin
    sum     = {1'b0, acc_q} + INC_W;
    acc_d   = '0;
    carry   = 1'b0;
    phase_d = 1'b0;
    if (state_d == RUN) begin
      acc_d   = sum[ACC_W-1:0];
      carry   = sum[ACC_W];
      phase_d = phase_q ^ sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= WAIT_LOCK;
      settle_cnt_q <= '0;
      acc_q        <= '0;
      phase_q      <= 1'b0;
      ce_q         <= 1'b0;
      ce_p1_q      <= 1'b0;
      ce_p2_q      <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      sync1_q      <= pll_lock;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      acc_q        <= acc_d;
      phase_q      <= phase_d;
      ce_q         <= carry;
      ce_p1_q      <= carry & ~phase_q;
      ce_p2_q      <= carry & phase_q;
      run_q        <= (state_d == RUN);
    end
  end

  assign ce         = ce_q;
  assign ce_p1      = ce_p1_q;
  assign ce_p2      = ce_p2_q;
  assign core_rst_n = run_q;
  assign locked     = run_q;

endmodule
